// File: rtl/decoder_2to4_seq_pkg.sv
// decoder_2to4_seq_pkg: shared state encodings and sizing constants for the sequenced decoder
package decoder_2to4_seq_pkg;
  localparam int N_LINES = 4;
  localparam int CODE_W = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_GAP = 2'd2} state_t;
endpackage

// File: rtl/decoder_2to4_seq_code_fifo2.sv
// code_fifo2: 2-deep code FIFO; pushes are refused while full even if a pop happens that cycle
module code_fifo2
  import decoder_2to4_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [CODE_W-1:0] dout
);
  logic [CODE_W-1:0] mem [2];
  logic rd, wr, do_push, do_pop;
  logic [1:0] cnt;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  // pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
    end else begin
      if (do_push) wr <= ~wr;
      if (do_pop) rd <= ~rd;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  // storage needs no reset: occupancy alone says which entries are live
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/decoder_2to4_seq.sv
// decoder_2to4_seq: turns buffered 2-bit codes into timed one-hot line pulses with hit counters
module decoder_2to4_seq
  import decoder_2to4_seq_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP = 1,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CODE_W-1:0]          in_code,
  input  logic                       en,
  output logic [N_LINES-1:0]         out_onehot,
  output logic                       done,
  output logic                       busy,
  output logic [N_LINES*CNT_W-1:0]   hit_cnt
);
  localparam int MX = HOLD > GAP ? HOLD : GAP;
  localparam int TW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [TW-1:0] HLD = TW'(HOLD - 1);
  localparam logic [TW-1:0] GP = TW'(GAP - 1);
  state_t state, nxt;
  logic [TW-1:0] timer, nxt_timer;
  logic [CODE_W-1:0] code, dout, nxt_code;
  logic full, empty, pop;
  logic [N_LINES-1:0][CNT_W-1:0] cnt;
  code_fifo2 u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .pop(pop),
    .din(in_code),
    .full(full),
    .empty(empty),
    .dout(dout)
  );
  assign in_ready = !full;
  assign busy = state != ST_IDLE || !empty;
  assign hit_cnt = cnt;
  assign pop = !empty && en && (state == ST_IDLE || (state == ST_GAP && timer == '0));
  assign nxt_code = pop ? dout : code;
  // next state and timer; a pop always restarts the hold
  always_comb begin
    nxt = pop ? ST_DRIVE :
          state == ST_DRIVE ? (timer == '0 ? ST_GAP : ST_DRIVE) :
          state == ST_GAP && timer == '0 ? ST_IDLE : state;
    nxt_timer = pop ? HLD :
                state == ST_DRIVE && timer == '0 ? GP :
                timer == '0 ? timer : timer - 1'b1;
  end
  // state, registered outputs and saturating hit counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      code <= '0;
      out_onehot <= '0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      timer <= nxt_timer;
      code <= nxt_code;
      out_onehot <= nxt == ST_DRIVE ? N_LINES'(1) << nxt_code : '0;
      done <= nxt == ST_DRIVE && nxt_timer == '0;
      if (pop && cnt[dout] != '1) cnt[dout] <= cnt[dout] + 1'b1;
    end
endmodule

// File: tb/tb_decoder_2to4_seq.sv
// tb_decoder_2to4_seq: scoreboard bench for the sequenced 2-to-4 decoder
module tb_decoder_2to4_seq;
  localparam int HOLD = 4, GAP = 1, CNT_W = 8;
  logic clk = 0, rst = 0, in_valid = 0, en = 0;
  logic [1:0] in_code = 0;
  logic in_ready, done, busy;
  logic [3:0] out_onehot;
  logic [4*CNT_W-1:0] hit_cnt;
  int tests = 0, fails = 0;
  logic [1:0] exp_q[$];
  logic [3:0] prev_oh = 0;
  int run = 0;
  bit saw_done = 0;

  always #5 clk = ~clk;

  decoder_2to4_seq #(.HOLD(HOLD), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_code(in_code),
    .en(en),
    .out_onehot(out_onehot),
    .done(done),
    .busy(busy),
    .hit_cnt(hit_cnt)
  );

  // scoreboard: each new one-hot pattern must match the oldest accepted code and last HOLD cycles
  always @(negedge clk) begin
    if (rst) begin
      prev_oh = 0;
      run = 0;
      saw_done = 0;
    end else begin
      if (out_onehot != 0 && prev_oh == 0) begin
        logic [1:0] c;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: out_onehot=%b but no code pending", out_onehot);
        end else begin
          c = exp_q.pop_front();
          if (out_onehot !== (4'b0001 << c)) begin
            fails++;
            $display("FAIL sb_order: out_onehot=%b required %b", out_onehot, 4'b0001 << c);
          end
        end
        run = 1;
        saw_done = done;
      end else if (out_onehot != 0) begin
        tests++;
        if (out_onehot !== prev_oh) begin
          fails++;
          $display("FAIL sb_hold_change: out_onehot=%b required %b", out_onehot, prev_oh);
        end
        run++;
        saw_done = saw_done | done;
      end else if (prev_oh != 0) begin
        tests++;
        if (run != HOLD || !saw_done) begin
          fails++;
          $display("FAIL sb_hold_len: hold=%0d done_seen=%0d required hold=%0d done_seen=1", run, saw_done, HOLD);
        end
      end
      prev_oh = out_onehot;
    end
  end

  task automatic send(input logic [1:0] c);
    int k = 0;
    @(negedge clk);
    in_valid = 1;
    in_code = c;
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%b required 1 for code %0d", in_ready, c);
    end else begin
      exp_q.push_back(c);
      @(posedge clk);
    end
    #1 in_valid = 0;
  endtask

  task automatic wait_idle(input string n);
    int k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", n, busy);
    end
  endtask

  task automatic check_idle_outputs(input string n);
    tests += 5;
    if (out_onehot !== 4'b0000) begin fails++; $display("FAIL %s_onehot: got %b required 0000", n, out_onehot); end
    if (done !== 1'b0) begin fails++; $display("FAIL %s_done: got %b required 0", n, done); end
    if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy: got %b required 0", n, busy); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready: got %b required 1", n, in_ready); end
    if (hit_cnt !== '0) begin fails++; $display("FAIL %s_hit_cnt: got %h required 0", n, hit_cnt); end
  endtask

  task automatic test_reset();
    rst = 1;
    en = 0;
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
  endtask

  task automatic test_single();
    logic [3:0] eo;
    en = 1;
    send(2'd2);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      eo = (c >= 1 && c <= 4) ? 4'b0100 : 4'b0000;
      tests += 3;
      if (out_onehot !== eo) begin fails++; $display("FAIL single_onehot_c%0d: got %b required %b", c, out_onehot, eo); end
      if (done !== (c == 4)) begin fails++; $display("FAIL single_done_c%0d: got %b required %b", c, done, c == 4); end
      if (busy !== (c <= 5)) begin fails++; $display("FAIL single_busy_c%0d: got %b required %b", c, busy, c <= 5); end
    end
    tests++;
    if (hit_cnt[2*CNT_W +: CNT_W] !== 8'd1) begin
      fails++;
      $display("FAIL single_hit2: got %0d required 1", hit_cnt[2*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_burst();
    en = 1;
    fork
      begin
        send(2'd0);
        send(2'd1);
        send(2'd3);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL burst_in_ready_full: got %b required 0", in_ready); end
      end
      begin
        int k = 0;
        logic [3:0] eo;
        @(negedge clk);
        while (out_onehot == 0 && k < 20) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 14; i++) begin
          eo = i < 4 ? 4'b0001 : i == 4 ? 4'b0000 : i < 9 ? 4'b0010 : i == 9 ? 4'b0000 : 4'b1000;
          tests++;
          if (out_onehot !== eo) begin fails++; $display("FAIL burst_seq_%0d: got %b required %b", i, out_onehot, eo); end
          if (i < 13) @(negedge clk);
        end
      end
    join
    wait_idle("burst");
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL burst_pending: %0d codes left required 0", exp_q.size()); end
  endtask

  task automatic test_en();
    int n = 1;
    en = 0;
    send(2'd1);
    send(2'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (out_onehot !== 4'b0000 || busy !== 1'b1) begin
        fails++;
        $display("FAIL en_hold_off_%0d: onehot=%b busy=%b required 0000 1", c, out_onehot, busy);
      end
    end
    en = 1;
    @(negedge clk);
    tests++;
    if (out_onehot !== 4'b0010) begin fails++; $display("FAIL en_start: got %b required 0010", out_onehot); end
    en = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_onehot !== 4'b0010) break;
      n++;
    end
    tests++;
    if (n != HOLD) begin fails++; $display("FAIL en_complete_hold: got %0d cycles required %0d", n, HOLD); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (out_onehot !== 4'b0000 || busy !== 1'b1) begin
        fails++;
        $display("FAIL en_paused_%0d: onehot=%b busy=%b required 0000 1", c, out_onehot, busy);
      end
    end
    en = 1;
    wait_idle("en");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    en = 1;
    send(2'd3);
    send(2'd0);
    while (out_onehot == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (out_onehot !== 4'b1000) begin fails++; $display("FAIL rstmid_drive: got %b required 1000", out_onehot); end
    @(negedge clk);
    #2 rst = 1;
    prev_oh = 0;
    run = 0;
    exp_q.delete();
    #1 check_idle_outputs("rstmid");
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (out_onehot !== 4'b0000 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_after_%0d: onehot=%b busy=%b required 0000 0", c, out_onehot, busy);
      end
    end
  endtask

  task automatic test_saturate();
    en = 1;
    for (int i = 0; i < 260; i++) send(2'd1);
    wait_idle("sat");
    tests += 2;
    if (hit_cnt[CNT_W +: CNT_W] !== 8'd255) begin
      fails++;
      $display("FAIL sat_hit1: got %0d required 255", hit_cnt[CNT_W +: CNT_W]);
    end
    if ({hit_cnt[4*CNT_W-1:2*CNT_W], hit_cnt[CNT_W-1:0]} !== '0) begin
      fails++;
      $display("FAIL sat_others: got %h required 0", hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_en();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
